// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - bin, computed LSB first, one bit per clock.
// One full-subtractor cell plus a borrow flop replace WIDTH parallel cells.
// start is accepted only in idle; d/bout/ovf are valid while done is high and
// hold their value until the next operation completes.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] r_sh_q;
  logic             br_q;
  logic [CntW-1:0]  cnt_q;
  logic             a_msb_q;
  logic             b_msb_q;

  logic             di;
  logic             br_d;
  logic [WIDTH-1:0] r_sh_d;

  // Full-subtractor cell on the current LSBs and the next result shift value.
  always_comb begin
    di     = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    br_d   = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    r_sh_d = {di, r_sh_q[WIDTH-1:1]};
  end

  // Control FSM, shift datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      d       <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            r_sh_q  <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            busy    <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          r_sh_q <= r_sh_d;
          br_q   <= br_d;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            d       <= r_sh_d;
            bout    <= br_d;
            // Overflow only possible when operand signs differ; then the
            // result sign must match the minuend sign.
            ovf     <= (a_msb_q != b_msb_q) && (r_sh_d[WIDTH-1] != a_msb_q);
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
